// File: rtl/axi_addr_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_addr_trace_buffer_if
// Brief    : Monitored AXI address channels, control pulses, trace output
//            stream and status for the address trace buffer.
// Revision : 1.0
// ============================================================================
interface axi_addr_trace_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32,
  parameter int TS_W   = 16
);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DATA_W = 1 + TS_W + ADDR_W;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              arm;
  logic              stop;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
  logic [7:0]        drop_cnt;
  logic [1:0]        state;

  modport master (
    output awvalid, awready, awaddr, arvalid, arready, araddr,
    output arm, stop, out_ready,
    input  out_valid, out_data, count, drop_cnt, state
  );

  modport slave (
    input  awvalid, awready, awaddr, arvalid, arready, araddr,
    input  arm, stop, out_ready,
    output out_valid, out_data, count, drop_cnt, state
  );
endinterface
`default_nettype wire

// File: rtl/axi_addr_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axi_addr_trace_buffer
// Brief    : Timestamped capture of AXI AW/AR handshakes into a circular
//            buffer, drained through a valid/ready stream.
// Revision : 1.0
// ============================================================================
module axi_addr_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32,
  parameter int TS_W   = 16
) (
  input  wire logic               clk,
  input  wire logic               rst_x,
  axi_addr_trace_buffer_if.slave  trc_if
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = 1 + TS_W + ADDR_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_FROZEN  = 2'd2;

  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        drop_q, drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              aw_ev_w, ar_ev_w, rec_w;
  logic              aw_push_w, ar_push_w, pop_w;
  logic [CNT_W-1:0]  free_w;
  logic [1:0]        drops_w;
  logic [8:0]        drop_sum_w;

  always_comb begin
    aw_ev_w   = trc_if.awvalid && trc_if.awready;
    ar_ev_w   = trc_if.arvalid && trc_if.arready;
    // An arm edge restarts capture, so that edge itself records nothing.
    rec_w     = (state_q == S_CAPTURE) && !trc_if.arm;
    free_w    = C_DEPTH - count_q;
    aw_push_w = rec_w && aw_ev_w && (free_w != '0);
    ar_push_w = rec_w && ar_ev_w && (free_w > CNT_W'(aw_push_w));
    drops_w   = {1'b0, rec_w && aw_ev_w && !aw_push_w}
              + {1'b0, rec_w && ar_ev_w && !ar_push_w};
    pop_w     = (count_q != '0) && trc_if.out_ready;

    wr_ptr_d  = wr_ptr_q + PTR_W'(aw_push_w) + PTR_W'(ar_push_w);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop_w);
    count_d   = count_q + CNT_W'(aw_push_w) + CNT_W'(ar_push_w) - CNT_W'(pop_w);

    drop_sum_w = {1'b0, drop_q} + {7'b0, drops_w};
    drop_d     = drop_sum_w[8] ? 8'hFF : drop_sum_w[7:0];
    ts_d       = ts_q;
    state_d    = state_q;

    if (trc_if.arm) begin
      state_d = S_CAPTURE;
      ts_d    = '0;
      drop_d  = '0;
    end else begin
      if (state_q == S_CAPTURE) begin
        ts_d = ts_q + TS_W'(1);
      end
      if (trc_if.stop && (state_q == S_CAPTURE)) begin
        state_d = S_FROZEN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q  <= S_IDLE;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (aw_push_w) begin
      mem_q[wr_ptr_q] <= {1'b1, ts_q, trc_if.awaddr};
    end
    if (ar_push_w) begin
      mem_q[wr_ptr_q + PTR_W'(aw_push_w)] <= {1'b0, ts_q, trc_if.araddr};
    end
  end

  assign trc_if.out_valid = (count_q != '0);
  assign trc_if.out_data  = mem_q[rd_ptr_q];
  assign trc_if.count     = count_q;
  assign trc_if.drop_cnt  = drop_q;
  assign trc_if.state     = state_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_addr_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_addr_trace_buffer
// Brief    : Self-checking bench: directed vector table, random stimulus
//            against a queue model, and multi-cycle corner sequences.
// Revision : 1.0
// ============================================================================
module tb_axi_addr_trace_buffer;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_x;
  always #5 clk = ~clk;

  axi_addr_trace_buffer_if #(.DEPTH(16), .ADDR_W(32), .TS_W(16)) bus  ();
  axi_addr_trace_buffer_if #(.DEPTH(4),  .ADDR_W(16), .TS_W(4))  bus2 ();

  axi_addr_trace_buffer #(.DEPTH(16), .ADDR_W(32), .TS_W(16)) dut (
    .clk(clk), .rst_x(rst_x), .trc_if(bus)
  );
  axi_addr_trace_buffer #(.DEPTH(4), .ADDR_W(16), .TS_W(4)) dut2 (
    .clk(clk), .rst_x(rst_x), .trc_if(bus2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered queue bounded at DEPTH entries.
  typedef struct { bit w; int unsigned ts; logic [31:0] a; } ent_t;
  ent_t        mq[$];
  int unsigned m_state, m_ts, m_drop;

  task automatic model_reset();
    mq.delete();
    m_state = 0;
    m_ts    = 0;
    m_drop  = 0;
  endtask

  task automatic model_step(input bit a_arm, input bit a_stop, input bit a_aw,
                            input logic [31:0] a_awa, input bit a_ar,
                            input logic [31:0] a_ara, input bit a_rdy);
    int space;
    bit rec;
    int lost;
    space = DEPTH - mq.size();
    rec   = (m_state == 1) && !a_arm;
    lost  = 0;
    if (mq.size() != 0 && a_rdy) void'(mq.pop_front());
    if (rec && a_aw) begin
      if (space > 0) begin mq.push_back('{1'b1, m_ts, a_awa}); space--; end
      else lost++;
    end
    if (rec && a_ar) begin
      if (space > 0) begin mq.push_back('{1'b0, m_ts, a_ara}); space--; end
      else lost++;
    end
    if (a_arm) m_drop = 0;
    else m_drop = (m_drop + lost > 255) ? 255 : m_drop + lost;
    if (a_arm) m_ts = 0;
    else if (m_state == 1) m_ts = (m_ts + 1) % 65536;
    if (a_arm) m_state = 1;
    else if (a_stop && m_state == 1) m_state = 2;
  endtask

  task automatic model_check(input string tag);
    logic [48:0] exp_d;
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'(mq.size() != 0));
    chk({tag, ".count"}, 64'(bus.count), 64'(mq.size()));
    chk({tag, ".drop"},  64'(bus.drop_cnt), 64'(m_drop));
    chk({tag, ".state"}, 64'(bus.state), 64'(m_state));
    if (mq.size() != 0) begin
      exp_d = {mq[0].w, 16'(mq[0].ts), mq[0].a};
      chk({tag, ".data"}, 64'(bus.out_data), 64'(exp_d));
    end
  endtask

  task automatic tick(input bit t_arm, input bit t_stop, input bit t_awv, input bit t_awr,
                      input logic [31:0] t_awa, input bit t_arv, input bit t_arr,
                      input logic [31:0] t_ara, input bit t_rdy);
    bus.arm = t_arm;   bus.stop = t_stop;
    bus.awvalid = t_awv; bus.awready = t_awr; bus.awaddr = t_awa;
    bus.arvalid = t_arv; bus.arready = t_arr; bus.araddr = t_ara;
    bus.out_ready = t_rdy;
    @(posedge clk);
    model_step(t_arm, t_stop, t_awv && t_awr, t_awa, t_arv && t_arr, t_ara, t_rdy);
    #1;
    model_check("model");
  endtask

  task automatic do_reset();
    rst_x = 1'b0;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst_x = 1'b1;
  endtask

  typedef struct {
    bit arm; bit stop; bit aw; logic [31:0] awa; bit ar; logic [31:0] ara; bit rdy;
    int cnt; bit vld; logic [48:0] dat; int drop; int st;
  } vec_t;
  vec_t vt[11];

  initial begin
    rst_x = 1'b0;
    bus.arm = 0; bus.stop = 0; bus.awvalid = 0; bus.awready = 0; bus.awaddr = '0;
    bus.arvalid = 0; bus.arready = 0; bus.araddr = '0; bus.out_ready = 0;
    bus2.arm = 0; bus2.stop = 0; bus2.awvalid = 0; bus2.awready = 0; bus2.awaddr = '0;
    bus2.arvalid = 0; bus2.arready = 0; bus2.araddr = '0; bus2.out_ready = 0;
    model_reset();

    vt[0]  = '{1,0,0,32'h0,0,32'h0,0,           0,0,49'h0,0,1};
    vt[1]  = '{0,0,0,32'h0,0,32'h0,0,           0,0,49'h0,0,1};
    vt[2]  = '{0,0,1,32'h4000_0010,0,32'h0,0,   1,1,{1'b1,16'h0001,32'h4000_0010},0,1};
    vt[3]  = '{0,0,1,32'hA0,1,32'hB0,0,         3,1,{1'b1,16'h0001,32'h4000_0010},0,1};
    vt[4]  = '{0,0,0,32'h0,0,32'h0,1,           2,1,{1'b1,16'h0002,32'hA0},0,1};
    vt[5]  = '{0,0,0,32'h0,0,32'h0,1,           1,1,{1'b0,16'h0002,32'hB0},0,1};
    vt[6]  = '{0,1,0,32'h0,1,32'h55,0,          2,1,{1'b0,16'h0002,32'hB0},0,2};
    vt[7]  = '{0,0,0,32'h0,1,32'h66,0,          2,1,{1'b0,16'h0002,32'hB0},0,2};
    vt[8]  = '{0,0,0,32'h0,0,32'h0,1,           1,1,{1'b0,16'h0005,32'h55},0,2};
    vt[9]  = '{0,0,0,32'h0,0,32'h0,1,           0,0,49'h0,0,2};
    vt[10] = '{1,1,0,32'h0,0,32'h0,0,           0,0,49'h0,0,1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 64'(bus.out_valid), 64'd0);
    chk("rst.count", 64'(bus.count), 64'd0);
    chk("rst.state", 64'(bus.state), 64'd0);
    chk("rst.drop",  64'(bus.drop_cnt), 64'd0);
    chk("rst2.count", 64'(bus2.count), 64'd0);
    rst_x = 1'b1;

    for (int i = 0; i < 11; i++) begin
      tick(vt[i].arm, vt[i].stop, vt[i].aw, vt[i].aw, vt[i].awa,
           vt[i].ar, vt[i].ar, vt[i].ara, vt[i].rdy);
      chk($sformatf("vec%0d.count", i), 64'(bus.count), 64'(vt[i].cnt));
      chk($sformatf("vec%0d.valid", i), 64'(bus.out_valid), 64'(vt[i].vld));
      chk($sformatf("vec%0d.state", i), 64'(bus.state), 64'(vt[i].st));
      chk($sformatf("vec%0d.drop", i),  64'(bus.drop_cnt), 64'(vt[i].drop));
      if (vt[i].vld) chk($sformatf("vec%0d.data", i), 64'(bus.out_data), 64'(vt[i].dat));
    end

    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom,
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 2) == 0);
    end

    // Fill to DEPTH-1, then a dual event only has room for AW.
    do_reset();
    tick(1,0, 0,0,32'h0, 0,0,32'h0, 0);
    for (int i = 0; i < 15; i++) tick(0,0, 1,1,32'h1000 + i, 0,0,32'h0, 0);
    chk("ovf.count15", 64'(bus.count), 64'd15);
    tick(0,0, 1,1,32'h2000, 1,1,32'h3000, 0);
    chk("ovf.count16", 64'(bus.count), 64'd16);
    chk("ovf.drop1",   64'(bus.drop_cnt), 64'd1);
    tick(0,0, 0,0,32'h0, 1,1,32'h3001, 0);
    chk("ovf.drop2",   64'(bus.drop_cnt), 64'd2);
    for (int i = 0; i < 300; i++) begin
      tick(0,0, 0,0,32'h0, 1,1,32'h4000 + i, 0);
      if (i == 252) chk("sat.drop255_edge", 64'(bus.drop_cnt), 64'd255);
    end
    chk("sat.drop255", 64'(bus.drop_cnt), 64'd255);

    tick(0,1, 0,0,32'h0, 0,0,32'h0, 0);
    chk("frz.state", 64'(bus.state), 64'd2);
    for (int i = 0; i < 3; i++) tick(0,0, 0,0,32'h0, 1,1,32'h5000 + i, 0);
    chk("frz.count", 64'(bus.count), 64'd16);
    for (int i = 0; i < 20 && bus.out_valid; i++) tick(0,0, 0,0,32'h0, 0,0,32'h0, 1);
    chk("drain.valid", 64'(bus.out_valid), 64'd0);
    chk("drain.count", 64'(bus.count), 64'd0);
    tick(1,0, 0,0,32'h0, 0,0,32'h0, 0);
    chk("rearm.drop", 64'(bus.drop_cnt), 64'd0);
    tick(0,0, 1,1,32'hCAFE, 0,0,32'h0, 0);
    chk("rearm.data", 64'(bus.out_data), 64'({1'b1, 16'h0000, 32'hCAFE}));

    // Asynchronous reset with five entries held mid-capture.
    tick(1,0, 0,0,32'h0, 0,0,32'h0, 0);
    for (int i = 0; i < 4; i++) tick(0,0, 1,1,32'h6000 + i, 0,0,32'h0, 0);
    chk("mrst.pre_count", 64'(bus.count), 64'd5);
    rst_x = 1'b0;
    #2;
    chk("mrst.valid", 64'(bus.out_valid), 64'd0);
    chk("mrst.count", 64'(bus.count), 64'd0);
    chk("mrst.state", 64'(bus.state), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_x = 1'b1;
    for (int i = 0; i < 3; i++) tick(0,0, 1,1,32'h7000, 1,1,32'h7100, 0);
    chk("mrst.norec", 64'(bus.count), 64'd0);

    // Narrow timestamp: 17 capture cycles wrap a 4-bit stamp to 1.
    bus2.arm = 1'b1;
    @(posedge clk);
    #1;
    bus2.arm = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    bus2.awvalid = 1'b1; bus2.awready = 1'b1; bus2.awaddr = 16'h1234;
    @(posedge clk);
    #1;
    bus2.awvalid = 1'b0; bus2.awready = 1'b0;
    chk("tsw.valid", 64'(bus2.out_valid), 64'd1);
    chk("tsw.count", 64'(bus2.count), 64'd1);
    chk("tsw.data",  64'(bus2.out_data), 64'({1'b1, 4'h1, 16'h1234}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
